// File: rtl/ps2_command_out.sv
// PS/2 host-to-device transmitter: requests the bus, shifts out one byte
// plus odd parity and stop on device clock edges, then checks the ACK.
//
// Ports:
//   clk, reset                    system clock, synchronous active-high reset
//   the_command[7:0]              byte to send, latched when a request is taken
//   send_command                  level request, held until a flag is seen
//   ps2_clk_posedge/negedge       one-cycle PS/2 clock edge strobes
//   ps2_data                      synchronised PS/2 data sample
//   ps2_clk_drive_low             1 = pull PS/2 clock low
//   ps2_dat_drive_low             1 = pull PS/2 data low
//   command_was_sent              byte sent and ACK seen
//   error_communication_timed_out timeout or bad ACK
module ps2_command_out #(
  parameter int CLOCK_CYCLES_FOR_101US = 5050,
  parameter int CLOCK_CYCLES_FOR_15MS  = 750000,
  parameter int CLOCK_CYCLES_FOR_2MS   = 100000,
  parameter int TIMER_WIDTH            = 20
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] the_command,
  input  logic       send_command,
  input  logic       ps2_clk_posedge,
  input  logic       ps2_clk_negedge,
  input  logic       ps2_data,
  output logic       ps2_clk_drive_low,
  output logic       ps2_dat_drive_low,
  output logic       command_was_sent,
  output logic       error_communication_timed_out
);

  localparam logic [TIMER_WIDTH-1:0] T_HOLD =
    TIMER_WIDTH'(CLOCK_CYCLES_FOR_101US - 1);
  localparam logic [TIMER_WIDTH-1:0] T_FIRST =
    TIMER_WIDTH'(CLOCK_CYCLES_FOR_15MS - 1);
  localparam logic [TIMER_WIDTH-1:0] T_XFER =
    TIMER_WIDTH'(CLOCK_CYCLES_FOR_2MS - 1);

  typedef enum logic [3:0] {
    IDLE,
    INIT,
    START,
    WAIT_CLK,
    DATA,
    PARITY,
    STOP,
    ACK,
    WAIT_REL,
    DONE,
    ERROR
  } state_t;

  state_t state, state_n;

  logic [TIMER_WIDTH-1:0] timer, timer_n;
  logic [2:0] bit_count, bit_count_n;
  logic [7:0] cmd_reg, cmd_n;
  logic       parity, parity_n;

  logic clk_low_n, dat_low_n;
  logic sent_n, err_n;

  // DATA..WAIT_REL share one timer that is never cleared mid-transfer,
  // so it bounds the whole byte; a timeout beats a coincident edge.
  always_comb begin
    state_n     = state;
    timer_n     = timer;
    bit_count_n = bit_count;
    cmd_n       = cmd_reg;
    parity_n    = parity;
    unique case (state)
      IDLE: begin
        if (send_command) begin
          cmd_n    = the_command;
          parity_n = ~^the_command;
          timer_n  = '0;
          state_n  = INIT;
        end
      end
      INIT: begin
        timer_n = timer + 1'b1;
        if (timer == T_HOLD)
          state_n = START;
      end
      START: begin
        timer_n = '0;
        state_n = WAIT_CLK;
      end
      WAIT_CLK: begin
        timer_n = timer + 1'b1;
        if (timer == T_FIRST) begin
          state_n = ERROR;
        end else if (ps2_clk_negedge) begin
          timer_n     = '0;
          bit_count_n = '0;
          state_n     = DATA;
        end
      end
      DATA, PARITY, STOP, ACK, WAIT_REL: begin
        timer_n = timer + 1'b1;
        if (timer == T_XFER) begin
          state_n = ERROR;
        end else begin
          unique case (1'b1)
            state == DATA: begin
              if (ps2_clk_negedge) begin
                bit_count_n = bit_count + 1'b1;
                if (bit_count == 3'd7)
                  state_n = PARITY;
              end
            end
            state == PARITY: begin
              if (ps2_clk_negedge)
                state_n = STOP;
            end
            state == STOP: begin
              if (ps2_clk_negedge)
                state_n = ACK;
            end
            state == ACK: begin
              if (ps2_clk_negedge)
                state_n = ps2_data ? ERROR : WAIT_REL;
            end
            default: begin
              if (ps2_clk_posedge)
                state_n = DONE;
            end
          endcase
        end
      end
      DONE, ERROR: begin
        if (!send_command)
          state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the registered pins
  // change on the same edge as the state register.
  always_comb begin
    clk_low_n = (state_n == INIT) || (state_n == START);
    dat_low_n = (state_n == START)
             || (state_n == WAIT_CLK)
             || ((state_n == DATA) && !cmd_n[bit_count_n])
             || ((state_n == PARITY) && !parity_n);
    sent_n    = (state_n == DONE);
    err_n     = (state_n == ERROR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state                         <= IDLE;
      timer                         <= '0;
      bit_count                     <= '0;
      cmd_reg                       <= '0;
      parity                        <= 1'b0;
      ps2_clk_drive_low             <= 1'b0;
      ps2_dat_drive_low             <= 1'b0;
      command_was_sent              <= 1'b0;
      error_communication_timed_out <= 1'b0;
    end else begin
      state                         <= state_n;
      timer                         <= timer_n;
      bit_count                     <= bit_count_n;
      cmd_reg                       <= cmd_n;
      parity                        <= parity_n;
      ps2_clk_drive_low             <= clk_low_n;
      ps2_dat_drive_low             <= dat_low_n;
      command_was_sent              <= sent_n;
      error_communication_timed_out <= err_n;
    end
  end

endmodule

// File: tb/tb_ps2_command_out.sv
// Bench for ps2_command_out: a PS/2 device model clocks the host
// transfer and the observed line is compared with the expected frame.
module tb_ps2_command_out;

  localparam int HOLD  = 8;
  localparam int FIRST = 40;
  localparam int XFER  = 200;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] the_command = '0;
  logic       send_command = 1'b0;
  logic       ps2_clk_posedge = 1'b0;
  logic       ps2_clk_negedge = 1'b0;
  logic       ps2_data = 1'b1;
  logic       ps2_clk_drive_low;
  logic       ps2_dat_drive_low;
  logic       command_was_sent;
  logic       error_communication_timed_out;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  ps2_command_out #(
    .CLOCK_CYCLES_FOR_101US(HOLD),
    .CLOCK_CYCLES_FOR_15MS(FIRST),
    .CLOCK_CYCLES_FOR_2MS(XFER),
    .TIMER_WIDTH(20)
  ) dut (
    .clk(clk),
    .reset(reset),
    .the_command(the_command),
    .send_command(send_command),
    .ps2_clk_posedge(ps2_clk_posedge),
    .ps2_clk_negedge(ps2_clk_negedge),
    .ps2_data(ps2_data),
    .ps2_clk_drive_low(ps2_clk_drive_low),
    .ps2_dat_drive_low(ps2_dat_drive_low),
    .command_was_sent(command_was_sent),
    .error_communication_timed_out(error_communication_timed_out)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Frame as seen on the wire: start 0, data LSB first, odd parity, stop 1.
  function automatic logic [10:0] frame(input logic [7:0] cmd);
    int ones = 0;
    for (int i = 0; i < 8; i++) ones += cmd[i];
    return {1'b1, (ones % 2 == 0) ? 1'b1 : 1'b0, cmd, 1'b0};
  endfunction

  function automatic logic [3:0] outs();
    return {ps2_clk_drive_low, ps2_dat_drive_low,
            command_was_sent, error_communication_timed_out};
  endfunction

  // mode 0: full transfer, 1: device silent,
  // 2: device stops after stop_at falling edges, 3: reset at stop_at
  task automatic run(input logic [7:0] cmd, input int mode,
                     input logic ack, input int stop_at);
    logic [10:0] line = '0;
    int lowcnt = 0;
    int g = 0;
    int t_rel;
    int t_data = 0;
    logic last_dat = 1'b0;
    @(negedge clk);
    the_command  = cmd;
    send_command = 1'b1;
    @(negedge clk);
    the_command = 8'($urandom);
    while (ps2_clk_drive_low && g < 100) begin
      lowcnt++;
      last_dat = ps2_dat_drive_low;
      @(negedge clk);
      g++;
    end
    check("clk_hold_cycles", lowcnt, HOLD + 1);
    check("start_bit_drive", last_dat, 1'b1);
    t_rel = cyc;
    if (mode == 1) begin
      g = 0;
      while (!error_communication_timed_out && g < 100) begin
        @(negedge clk);
        g++;
      end
      check("first_edge_timeout", cyc - t_rel, FIRST);
      check("timeout_released", outs(), 4'b0001);
    end else begin
      for (int e = 0; e < 12; e++) begin
        if (mode == 2 && e == stop_at) break;
        if (mode == 3 && e == stop_at) begin
          repeat (2) @(negedge clk);
          reset = 1'b1;
          @(negedge clk);
          check("reset_mid_data", outs(), 4'b0000);
          reset = 1'b0;
          send_command = 1'b0;
          @(negedge clk);
          check("idle_after_reset", outs(), 4'b0000);
          return;
        end
        repeat (4) @(negedge clk);
        if (e < 11) line[e] = ~ps2_dat_drive_low;
        else ps2_data = ack;
        ps2_clk_negedge = 1'b1;
        @(negedge clk);
        ps2_clk_negedge = 1'b0;
        if (e == 0) t_data = cyc;
        repeat (4) @(negedge clk);
        ps2_clk_posedge = 1'b1;
        @(negedge clk);
        ps2_clk_posedge = 1'b0;
        ps2_data = 1'b1;
      end
      if (mode == 2) begin
        g = 0;
        while (!error_communication_timed_out && g < 400) begin
          @(negedge clk);
          g++;
        end
        check("xfer_timeout", cyc - t_data, XFER);
        check("xfer_to_released", outs(), 4'b0001);
      end else begin
        check("wire_frame", line, frame(cmd));
        g = 0;
        while (!(command_was_sent || error_communication_timed_out)
               && g < 50) begin
          @(negedge clk);
          g++;
        end
        check("result_flags", outs(), ack ? 4'b0001 : 4'b0010);
      end
    end
    repeat (3) @(negedge clk);
    check("flag_held", command_was_sent | error_communication_timed_out,
          1'b1);
    send_command = 1'b0;
    @(negedge clk);
    check("flag_cleared", outs(), 4'b0000);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("reset_outputs", outs(), 4'b0000);
    reset = 1'b0;
    @(negedge clk);
    check("idle_outputs", outs(), 4'b0000);
    run(8'hFF, 0, 1'b0, 0);
    run(8'hF4, 0, 1'b0, 0);
    run(8'hED, 1, 1'b0, 0);
    run(8'h5A, 0, 1'b1, 0);
    run(8'h3C, 2, 1'b0, 5);
    run(8'h96, 3, 1'b0, 4);
    run(8'hAA, 0, 1'b0, 0);
    for (int i = 0; i < 6; i++)
      run(8'($urandom), 0, ($urandom_range(0, 3) == 0), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
